// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer: FSM states,
// decoded path indices and PC source selects.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_PCUPD  = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    localparam logic [3:0] PATH_MOVE   = 4'd0;
    localparam logic [3:0] PATH_ALU    = 4'd1;
    localparam logic [3:0] PATH_LW     = 4'd2;
    localparam logic [3:0] PATH_SW     = 4'd3;
    localparam logic [3:0] PATH_BEQ    = 4'd4;
    localparam logic [3:0] PATH_J      = 4'd5;
    localparam logic [3:0] PATH_JAL    = 4'd6;
    localparam logic [3:0] PATH_MULDIV = 4'd7;
    localparam logic [3:0] PATH_JR     = 4'd8;
    localparam logic [3:0] PATH_EXIT   = 4'd9;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;
    localparam logic [1:0] PCSEL_REG = 2'b11;

endpackage

// File: rtl/seq_timeout_counter.sv
// Loadable down-counter acting as the mult/div watchdog; expired is high
// whenever the count sits at zero.
module seq_timeout_counter #(
    parameter int unsigned    W        = 7,
    parameter logic [W-1:0]   LOAD_VAL = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM stepping the MIPS datapath through fetch, decode,
// execute, memory, writeback and PC update with one-hot stage strobes.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MULDIV_TIMEOUT = 64,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             instr_valid,
    input  logic             decoder_done,
    input  logic [3:0]       path_index,
    input  logic             alu_zero,
    input  logic             alu_done,
    input  logic             mem_ack,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             alu_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             link_sel,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned      TO_W    = $clog2(MULDIV_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(MULDIV_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [3:0]       path_q, path_d;
    logic             dec_second_q, dec_second_d;
    logic [1:0]       pc_sel_q, pc_sel_d;
    logic             link_sel_q, link_sel_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             to_load, to_dec, to_expired;

    seq_timeout_counter #(
        .W        (TO_W),
        .LOAD_VAL (TO_LOAD)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (to_load),
        .dec     (to_dec),
        .expired (to_expired)
    );

    always_comb begin
        state_d      = state_q;
        path_d       = path_q;
        dec_second_d = (state_q == ST_DECODE);
        pc_sel_d     = PCSEL_SEQ;
        link_sel_d   = 1'b0;
        error_d      = error_q;
        retired_d    = retired_q;
        to_load      = 1'b0;
        to_dec       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // The first DECODE cycle may still see a stale done from the decoder.
                if (dec_second_q && decoder_done) begin
                    path_d  = path_index;
                    to_load = 1'b1;
                    case (path_index)
                        PATH_MOVE: state_d = ST_WB;
                        PATH_ALU, PATH_LW, PATH_SW, PATH_BEQ, PATH_MULDIV: state_d = ST_EXEC;
                        PATH_J: begin
                            state_d  = ST_PCUPD;
                            pc_sel_d = PCSEL_JMP;
                        end
                        PATH_JAL: begin
                            state_d    = ST_WB;
                            link_sel_d = 1'b1;
                        end
                        PATH_JR: begin
                            state_d  = ST_PCUPD;
                            pc_sel_d = PCSEL_REG;
                        end
                        PATH_EXIT: state_d = ST_HALT;
                        default: begin
                            state_d = ST_PCUPD;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                case (path_q)
                    PATH_MULDIV: begin
                        to_dec = 1'b1;
                        if (alu_done) begin
                            state_d = ST_PCUPD;
                        end else if (to_expired) begin
                            state_d = ST_HALT;
                            error_d = 1'b1;
                        end
                    end
                    PATH_ALU: state_d = ST_WB;
                    PATH_LW, PATH_SW: state_d = ST_MEM;
                    PATH_BEQ: begin
                        state_d  = ST_PCUPD;
                        pc_sel_d = alu_zero ? PCSEL_BR : PCSEL_SEQ;
                    end
                    default: state_d = ST_PCUPD;
                endcase
            end
            ST_MEM: begin
                if (mem_ack) state_d = (path_q == PATH_LW) ? ST_WB : ST_PCUPD;
            end
            ST_WB: begin
                state_d = ST_PCUPD;
                if (path_q == PATH_JAL) pc_sel_d = PCSEL_JMP;
            end
            ST_PCUPD: begin
                state_d   = ST_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            path_q       <= PATH_MOVE;
            dec_second_q <= 1'b0;
            pc_sel_q     <= PCSEL_SEQ;
            link_sel_q   <= 1'b0;
            error_q      <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            path_q       <= path_d;
            dec_second_q <= dec_second_d;
            pc_sel_q     <= pc_sel_d;
            link_sel_q   <= link_sel_d;
            error_q      <= error_d;
            retired_q    <= retired_d;
        end
    end

    assign fetch_en  = (state_q == ST_FETCH);
    assign decode_en = (state_q == ST_DECODE);
    assign alu_en    = (state_q == ST_EXEC);
    assign mem_en    = (state_q == ST_MEM);
    assign wb_en     = (state_q == ST_WB);
    assign pc_en     = (state_q == ST_PCUPD);
    assign halted    = (state_q == ST_HALT);
    assign pc_sel    = pc_sel_q;
    assign link_sel  = link_sel_q;
    assign error     = error_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: a per-instruction trace model predicts
// the stage of every cycle and the expected pc_sel/link_sel/error/retired.
module tb_instr_sequencer;

    localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_P = 5, S_H = 6, S_I = 7;

    logic        clk = 1'b0;
    logic        rst_n, start, instr_valid, decoder_done, alu_zero, alu_done, mem_ack;
    logic [3:0]  path_index;
    logic        fetch_en, decode_en, alu_en, mem_en, wb_en, link_sel, pc_en, halted, error;
    logic [1:0]  pc_sel;
    logic [31:0] retired;

    always #5 clk = ~clk;

    instr_sequencer #(.MULDIV_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_valid(instr_valid),
        .decoder_done(decoder_done), .path_index(path_index), .alu_zero(alu_zero),
        .alu_done(alu_done), .mem_ack(mem_ack), .fetch_en(fetch_en), .decode_en(decode_en),
        .alu_en(alu_en), .mem_en(mem_en), .wb_en(wb_en), .link_sel(link_sel), .pc_en(pc_en),
        .pc_sel(pc_sel), .halted(halted), .error(error), .retired(retired)
    );

    typedef struct {
        int         stg;
        logic [1:0] pcsel;
        logic       link;
        logic       err;
        int         ret;
        int         idx;
    } exp_t;

    exp_t eq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_err;
    int   m_ret;

    function automatic logic [5:0] strobe_of(input int stg);
        case (stg)
            S_F:     return 6'b100000;
            S_D:     return 6'b010000;
            S_E:     return 6'b001000;
            S_M:     return 6'b000100;
            S_W:     return 6'b000010;
            S_P:     return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle(input exp_t e);
        logic [5:0] strobes;
        strobes = {fetch_en, decode_en, alu_en, mem_en, wb_en, pc_en};
        check_val("strobes",  64'(strobes),  64'(strobe_of(e.stg)));
        check_val("onehot",   64'($countones(strobes) <= 1), 64'(1));
        check_val("pc_sel",   64'(pc_sel),   64'((e.stg == S_P) ? e.pcsel : 2'b00));
        check_val("link_sel", 64'(link_sel), 64'((e.stg == S_W) ? e.link : 1'b0));
        check_val("halted",   64'(halted),   64'(e.stg == S_H));
        check_val("error",    64'(error),    64'(e.err));
        check_val("retired",  64'(retired),  64'(unsigned'(e.ret)));
    endtask

    task automatic push(input int stg, input int n, input logic [1:0] ps, input logic lk);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.stg = stg; e.pcsel = ps; e.link = lk; e.err = m_err; e.ret = m_ret; e.idx = k;
            eq.push_back(e);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.stg = S_I; e.pcsel = 2'b00; e.link = 1'b0; e.err = m_err; e.ret = m_ret; e.idx = 0;
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        m_err = 1'b0;
        m_ret = 0;
        @(negedge clk);
        check_cycle(idle_exp());
        @(negedge clk);
        check_cycle(idle_exp());
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        @(negedge clk);
        check_cycle(idle_exp());
        start = 1'b1;
    endtask

    // fw: FETCH cycles before instr_valid; dd: DECODE cycle (1-based) where done rises;
    // mw: MEM cycles before mem_ack; aw: EXEC cycle of alu_done (0 = never).
    task automatic run_instr(input logic [3:0] p, input int fw, input int dd, input int mw,
                             input int aw, input logic zero, input int abort_at);
        logic [1:0] ps;
        logic       stop;
        eq.delete();
        stop = 1'b0;
        push(S_F, fw + 1, 2'b00, 1'b0);
        push(S_D, (dd < 2) ? 2 : dd, 2'b00, 1'b0);
        ps = 2'b00;
        case (p)
            4'd0: push(S_W, 1, 2'b00, 1'b0);
            4'd1: begin push(S_E, 1, 2'b00, 1'b0); push(S_W, 1, 2'b00, 1'b0); end
            4'd2: begin push(S_E, 1, 2'b00, 1'b0); push(S_M, mw + 1, 2'b00, 1'b0);
                        push(S_W, 1, 2'b00, 1'b0); end
            4'd3: begin push(S_E, 1, 2'b00, 1'b0); push(S_M, mw + 1, 2'b00, 1'b0); end
            4'd4: begin push(S_E, 1, 2'b00, 1'b0); ps = zero ? 2'b01 : 2'b00; end
            4'd5: ps = 2'b10;
            4'd6: begin push(S_W, 1, 2'b00, 1'b1); ps = 2'b10; end
            4'd7: begin
                if (aw >= 1 && aw <= 64) begin
                    push(S_E, aw, 2'b00, 1'b0);
                end else begin
                    push(S_E, 64, 2'b00, 1'b0);
                    stop = 1'b1;
                    m_err = 1'b1;
                end
            end
            4'd8: ps = 2'b11;
            4'd9: stop = 1'b1;
            default: m_err = 1'b1;
        endcase
        if (stop) begin
            push(S_H, 4, 2'b00, 1'b0);
        end else begin
            push(S_P, 1, ps, 1'b0);
            m_ret++;
        end

        for (int i = 0; i < eq.size(); i++) begin
            exp_t e;
            e = eq[i];
            @(negedge clk);
            check_cycle(e);
            if (i == abort_at) begin
                rst_n   = 1'b0;
                mem_ack = 1'b0;
                $display("instr path=%0d aborted by reset after %0d cycles", p, i + 1);
                return;
            end
            start        = (e.stg == S_H) ? 1'b1 : 1'($urandom_range(0, 1));
            path_index   = (e.stg == S_D) ? p : 4'($urandom_range(0, 15));
            instr_valid  = (e.stg == S_F) ? (e.idx == fw) : 1'($urandom_range(0, 1));
            decoder_done = (e.stg == S_D) ? (e.idx >= dd - 1) : 1'($urandom_range(0, 1));
            mem_ack      = (e.stg == S_M) ? (e.idx == mw) : 1'($urandom_range(0, 1));
            alu_done     = (e.stg == S_E && p == 4'd7) ? (aw > 0 && e.idx == aw - 1)
                                                       : 1'($urandom_range(0, 1));
            alu_zero     = (e.stg == S_E) ? zero : 1'($urandom_range(0, 1));
        end
        $display("instr path=%0d cycles=%0d halted=%0b error=%0b retired=%0d",
                 p, eq.size(), halted, error, retired);
    endtask

    initial begin
        logic [3:0] rp;
        rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0; decoder_done = 1'b0;
        path_index = 4'd0; alu_zero = 1'b0; alu_done = 1'b0; mem_ack = 1'b0;
        m_err = 1'b0; m_ret = 0;

        do_reset();
        start_run();
        run_instr(4'd1, 0, 2, 0, 0, 1'b0, -1);   // add: 6 cycles
        run_instr(4'd4, 0, 2, 0, 0, 1'b1, -1);   // beq taken
        run_instr(4'd4, 1, 1, 0, 0, 1'b0, -1);   // beq not taken, stale done in first DECODE
        run_instr(4'd2, 0, 2, 3, 0, 1'b0, -1);   // lw: mem_ack after 3 wait cycles
        run_instr(4'd3, 2, 3, 1, 0, 1'b0, -1);   // sw
        run_instr(4'd7, 0, 2, 0, 10, 1'b0, -1);  // mult done at EXEC cycle 10
        run_instr(4'd7, 0, 2, 0, 64, 1'b0, -1);  // done coincides with watchdog expiry
        run_instr(4'd5, 0, 2, 0, 0, 1'b0, -1);   // j: 4 cycles
        run_instr(4'd8, 0, 4, 0, 0, 1'b0, -1);   // jr
        run_instr(4'd0, 0, 2, 0, 0, 1'b0, -1);   // mfhi
        run_instr(4'd6, 0, 2, 0, 0, 1'b0, -1);   // jal
        run_instr(4'd9, 0, 2, 0, 0, 1'b0, -1);   // exit -> HALT, start ignored

        do_reset();
        start_run();
        run_instr(4'd6, 1, 2, 0, 0, 1'b0, -1);
        run_instr(4'd9, 0, 3, 0, 0, 1'b0, -1);   // halts with retired=1

        do_reset();
        start_run();
        run_instr(4'd12, 0, 2, 0, 0, 1'b0, -1);  // illegal: error sticks, continues
        for (int n = 0; n < 40; n++) begin
            rp = 4'($urandom_range(0, 15));
            if (rp == 4'd9) rp = 4'd1;
            run_instr(rp, $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 4),
                      (rp == 4'd7) ? $urandom_range(1, 12) : 0, 1'($urandom_range(0, 1)), -1);
        end
        run_instr(4'd2, 0, 2, 20, 0, 1'b0, 6);   // reset while waiting for mem_ack
        do_reset();

        start_run();
        run_instr(4'd1, 0, 2, 0, 0, 1'b0, -1);
        run_instr(4'd7, 0, 2, 0, 0, 1'b0, -1);   // watchdog expires -> error + HALT

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required end within 50000 cycles");
        $fatal(1, "simulation time limit reached");
    end

endmodule
